// File: rtl/pri_arb_rr_pkg.sv
// ---------------------------------------------------------------------------
// pri_arb_rr_pkg
//   Shared definitions for the N-channel arbiter/selector:
//   - arbitration mode selectors (fixed priority / round-robin)
//   - arb_clog2(): constant-evaluable ceiling log2 used to size channel indices
// ---------------------------------------------------------------------------
package pri_arb_rr_pkg;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

  // Ceiling log2, with a floor of 1 bit so an index is never zero-width.
  function automatic int arb_clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pri_arb_rr_if.sv
// ---------------------------------------------------------------------------
// pri_arb_rr_if
//   Bundles the N input channels and the single output port of pri_arb_rr.
//   Signals:
//     in_valid  [N_CH]        per-channel request
//     in_data   [N_CH*WIDTH]  channel k word at [k*WIDTH +: WIDTH]
//     in_ready  [N_CH]        one-hot (or zero) accept strobe
//     out_valid               registered output word valid
//     out_data  [WIDTH]       registered winning word
//     out_ch    [IDX_W]       registered index of the supplying channel
//     out_ready               downstream accept
//   Handshake: a word moves on a rising edge where valid & ready are both 1.
//   A producer holding valid=1 must keep its word stable until it sees ready;
//   ready may depend combinationally on valid, valid never depends on ready.
//   Modports: slave = arbiter view, master = producer/consumer (bench) view.
// ---------------------------------------------------------------------------
interface pri_arb_rr_if
  import pri_arb_rr_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int IDX_W = arb_clog2(N_CH);

  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [IDX_W-1:0]      out_ch;
  logic                  out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/pri_arb_rr_ffs_onehot.sv
// ---------------------------------------------------------------------------
// ffs_onehot
//   Combinational find-first-set: lowest set bit of req wins.
//   Ports:
//     req    [N]   request vector
//     onehot [N]   one-hot of the lowest set bit (all zero when no request)
//     idx    [IW]  index of that bit (0 when no request)
//     any          1 when any request bit is set
// ---------------------------------------------------------------------------
module ffs_onehot
  import pri_arb_rr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              req,
  output logic [N-1:0]              onehot,
  output logic [arb_clog2(N)-1:0]   idx,
  output logic                      any
);
  localparam int IW = arb_clog2(N);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (req[k] && !any) begin
        onehot[IW'(k)] = 1'b1;
        idx            = IW'(k);
        any            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pri_arb_rr.sv
// ---------------------------------------------------------------------------
// pri_arb_rr
//   N-channel arbiter/selector with a registered output stage. One winner per
//   cycle (fixed priority, ch0 highest, or round-robin) is accepted and its
//   word appears on the output port on the following cycle.
//   Ports:
//     clk         rising-edge clock
//     rst         asynchronous active-high reset
//     bus         pri_arb_rr_if.slave (input channels + output port)
//     dbg_rr_ptr  current round-robin search start (always 0 in fixed mode)
// ---------------------------------------------------------------------------
module pri_arb_rr
  import pri_arb_rr_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = ARB_MODE_FIXED
) (
  input  logic                       clk,
  input  logic                       rst,
  pri_arb_rr_if.slave                bus,
  output logic [arb_clog2(N_CH)-1:0] dbg_rr_ptr
);
  localparam int IDX_W = arb_clog2(N_CH);

  logic [N_CH-1:0]  win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             ld;
  logic [WIDTH-1:0] mux_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [IDX_W-1:0] out_ch_q,    out_ch_d;
  logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
  if (MODE == ARB_MODE_RR) begin : g_rr
    logic [N_CH-1:0]  rot_req;
    logic [N_CH-1:0]  rot_oh;
    logic [IDX_W-1:0] rot_idx;
    logic             rot_any;

    // Rotate right by rr_ptr so position 0 is the channel searched first.
    // Wrap is an explicit compare so non-power-of-2 N_CH stays correct.
    always_comb begin
      int src;
      rot_req = '0;
      for (int j = 0; j < N_CH; j++) begin
        src = j + int'(rr_ptr_q);
        if (src >= N_CH) src = src - N_CH;
        rot_req[IDX_W'(j)] = bus.in_valid[IDX_W'(src)];
      end
    end

    ffs_onehot #(.N(N_CH)) u_ffs (
      .req    (rot_req),
      .onehot (rot_oh),
      .idx    (rot_idx),
      .any    (rot_any)
    );

    // Undo the rotation on both the one-hot and the index.
    always_comb begin
      int src;
      int sum;
      win_oh = '0;
      for (int j = 0; j < N_CH; j++) begin
        src = j + int'(rr_ptr_q);
        if (src >= N_CH) src = src - N_CH;
        win_oh[IDX_W'(src)] = rot_oh[IDX_W'(j)];
      end
      sum = int'(rot_idx) + int'(rr_ptr_q);
      if (sum >= N_CH) sum = sum - N_CH;
      win_idx = IDX_W'(sum);
      win_any = rot_any;
    end
  end else begin : g_fixed
    ffs_onehot #(.N(N_CH)) u_ffs (
      .req    (bus.in_valid),
      .onehot (win_oh),
      .idx    (win_idx),
      .any    (win_any)
    );
  end

  // Output register can take a word when empty or being drained this cycle.
  assign ld = ~out_valid_q | bus.out_ready;

  // Accept strobe; forced low during reset so no producer sees a false accept.
  assign bus.in_ready = (ld && !rst) ? win_oh : '0;

  // AND-OR data select keyed by the one-hot winner.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      mux_data = mux_data | (bus.in_data[k*WIDTH +: WIDTH] & {WIDTH{win_oh[IDX_W'(k)]}});
    end
  end

  // -------------------------------------------------------------------------
  // Next state
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (ld) begin
      // With no request the word is dropped from valid but its value is kept.
      out_valid_d = win_any;
      if (win_any) begin
        out_data_d = mux_data;
        out_ch_d   = win_idx;
        if (MODE == ARB_MODE_RR) begin
          rr_ptr_d = (win_idx == IDX_W'(N_CH - 1)) ? '0 : win_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign dbg_rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_pri_arb_rr.sv
// ---------------------------------------------------------------------------
// tb_pri_arb_rr
//   Three instances: fixed N=4, round-robin N=4, round-robin N=5.
//   Index 0/1/2 below selects the instance being exercised.
// ---------------------------------------------------------------------------
module tb_pri_arb_rr;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  pri_arb_rr_if #(.N_CH(4), .WIDTH(8)) if_fix ();
  pri_arb_rr_if #(.N_CH(4), .WIDTH(8)) if_rr  ();
  pri_arb_rr_if #(.N_CH(5), .WIDTH(8)) if_rr5 ();

  logic [1:0] ptr_fix, ptr_rr;
  logic [2:0] ptr_rr5;

  pri_arb_rr #(.N_CH(4), .WIDTH(8), .MODE(0)) u_fix (
    .clk(clk), .rst(rst), .bus(if_fix.slave), .dbg_rr_ptr(ptr_fix));
  pri_arb_rr #(.N_CH(4), .WIDTH(8), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .bus(if_rr.slave), .dbg_rr_ptr(ptr_rr));
  pri_arb_rr #(.N_CH(5), .WIDTH(8), .MODE(1)) u_rr5 (
    .clk(clk), .rst(rst), .bus(if_rr5.slave), .dbg_rr_ptr(ptr_rr5));

  // ---------------- drive / observe wiring ----------------
  logic [7:0]  drv_iv   [3];
  logic [39:0] drv_data [3];
  logic        drv_ordy [3];

  assign if_fix.in_valid  = drv_iv[0][3:0];
  assign if_fix.in_data   = drv_data[0][31:0];
  assign if_fix.out_ready = drv_ordy[0];
  assign if_rr.in_valid   = drv_iv[1][3:0];
  assign if_rr.in_data    = drv_data[1][31:0];
  assign if_rr.out_ready  = drv_ordy[1];
  assign if_rr5.in_valid  = drv_iv[2][4:0];
  assign if_rr5.in_data   = drv_data[2];
  assign if_rr5.out_ready = drv_ordy[2];

  logic [7:0] act_ir [3];
  logic [7:0] act_ov [3];
  logic [7:0] act_ch [3];
  logic [7:0] act_dt [3];
  logic [7:0] act_pt [3];

  assign act_ir[0] = 8'(if_fix.in_ready);
  assign act_ir[1] = 8'(if_rr.in_ready);
  assign act_ir[2] = 8'(if_rr5.in_ready);
  assign act_ov[0] = 8'(if_fix.out_valid);
  assign act_ov[1] = 8'(if_rr.out_valid);
  assign act_ov[2] = 8'(if_rr5.out_valid);
  assign act_ch[0] = 8'(if_fix.out_ch);
  assign act_ch[1] = 8'(if_rr.out_ch);
  assign act_ch[2] = 8'(if_rr5.out_ch);
  assign act_dt[0] = if_fix.out_data;
  assign act_dt[1] = if_rr.out_data;
  assign act_dt[2] = if_rr5.out_data;
  assign act_pt[0] = 8'(ptr_fix);
  assign act_pt[1] = 8'(ptr_rr);
  assign act_pt[2] = 8'(ptr_rr5);

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [15:0] exp_q[$];     // {out_ch, out_data} expected on the output port
  int          m_ptr  [3];
  logic        m_ov   [3];
  logic [15:0] m_last [3];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int n_of(input int sel);
    return (sel == 2) ? 5 : 4;
  endfunction

  function automatic int mode_of(input int sel);
    return (sel == 0) ? 0 : 1;
  endfunction

  // Reference arbitration: walk channels in search order, first valid wins.
  function automatic int model_winner(input logic [7:0] iv, input int n, input int mode, input int ptr);
    for (int i = 0; i < n; i++) begin
      int k;
      k = (mode == 1) ? ((ptr + i) % n) : i;
      if (iv[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_ptr[s]  = 0;
      m_ov[s]   = 1'b0;
      m_last[s] = '0;
    end
    exp_q.delete();
  endtask

  // One clock cycle on instance sel. Entered just after a falling edge.
  task automatic cycle(input int sel, input logic [7:0] iv, input logic [39:0] data,
                       input logic ordy, input logic use_tbl, input logic [7:0] tbl_ir);
    int n;
    int w;
    logic ld;
    logic [7:0] exp_ir;
    logic [15:0] word;
    n = n_of(sel);
    // Outputs produced by the previous rising edge.
    chk("out_valid", 40'(act_ov[sel]), 40'(m_ov[sel]));
    if (m_ov[sel]) begin
      word = (exp_q.size() > 0) ? exp_q[0] : 16'h0;
      chk("out_word", {24'h0, act_ch[sel], act_dt[sel]}, {24'h0, word});
    end else begin
      chk("held_word", {24'h0, act_ch[sel], act_dt[sel]}, {24'h0, m_last[sel]});
    end
    chk("rr_ptr", 40'(act_pt[sel]), 40'(m_ptr[sel]));
    if (sel == 2) chk("out_ch_range", 40'(act_ch[2] <= 8'd4), 40'(1));
    // New inputs for this cycle.
    drv_iv[sel]   = iv;
    drv_data[sel] = data;
    drv_ordy[sel] = ordy;
    #1;
    ld = !m_ov[sel] || ordy;
    w  = ld ? model_winner(iv, n, mode_of(sel), m_ptr[sel]) : -1;
    exp_ir = (w >= 0) ? 8'(1 << w) : 8'h0;
    chk("in_ready", 40'(act_ir[sel]), 40'(exp_ir));
    if (use_tbl) chk("tbl_in_ready", 40'(act_ir[sel]), 40'(tbl_ir));
    if (m_ov[sel] && ordy) void'(exp_q.pop_front());
    if (w >= 0) begin
      word = {8'(w), data[w*8 +: 8]};
      exp_q.push_back(word);
      m_last[sel] = word;
      m_ov[sel]   = 1'b1;
      if (mode_of(sel) == 1) m_ptr[sel] = (w + 1 == n) ? 0 : w + 1;
    end else if (ld) begin
      m_ov[sel] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int sel, input int cycles);
    for (int i = 0; i < cycles; i++) cycle(sel, 8'h0, 40'h0, 1'b1, 1'b0, 8'h0);
  endtask

  function automatic logic [39:0] rnd_data();
    return {8'($urandom), 32'($urandom)};
  endfunction

  // ---------------- fixed-priority vector table ----------------
  typedef struct {
    logic [3:0]  iv;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_ir;
  } vec_t;

  vec_t tbl[15];

  initial begin
    for (int s = 0; s < 3; s++) begin
      drv_iv[s]   = 8'hFF;
      drv_data[s] = 40'h0;
      drv_ordy[s] = 1'b1;
    end
    model_reset();

    tbl[0]  = '{4'b1010, 32'h33221100, 1'b1, 4'b0010};
    tbl[1]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000};
    tbl[2]  = '{4'b1111, 32'hD4C3B2A1, 1'b1, 4'b0001};
    tbl[3]  = '{4'b1110, 32'hD4C3B2A1, 1'b0, 4'b0000};
    tbl[4]  = '{4'b1110, 32'hD4C3B2A1, 1'b0, 4'b0000};
    tbl[5]  = '{4'b1110, 32'hD4C3B2A1, 1'b0, 4'b0000};
    tbl[6]  = '{4'b1110, 32'hD4C3B2A1, 1'b1, 4'b0010};
    tbl[7]  = '{4'b1000, 32'h5A000000, 1'b1, 4'b1000};
    tbl[8]  = '{4'b1100, 32'h77660000, 1'b1, 4'b0100};
    tbl[9]  = '{4'b0000, 32'h00000000, 1'b1, 4'b0000};
    tbl[10] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000};
    tbl[11] = '{4'b0001, 32'h000000EE, 1'b0, 4'b0001};
    tbl[12] = '{4'b0010, 32'h0000FF00, 1'b0, 4'b0000};
    tbl[13] = '{4'b0010, 32'h0000FF00, 1'b1, 4'b0010};
    tbl[14] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000};

    // Reset state, with every channel requesting.
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("rst_out_valid", 40'(act_ov[s]), 40'h0);
      chk("rst_out_word",  {24'h0, act_ch[s], act_dt[s]}, 40'h0);
      chk("rst_in_ready",  40'(act_ir[s]), 40'h0);
      chk("rst_rr_ptr",    40'(act_pt[s]), 40'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) drv_iv[s] = 8'h0;

    // Fixed priority: table, then random traffic.
    for (int i = 0; i < 15; i++) begin
      cycle(0, 8'(tbl[i].iv), 40'(tbl[i].data), tbl[i].ordy, 1'b1, 8'(tbl[i].exp_ir));
    end
    for (int i = 0; i < 60; i++) begin
      cycle(0, 8'($urandom_range(0, 15)), rnd_data(),
            ($urandom_range(0, 3) != 0), 1'b0, 8'h0);
    end
    idle(0, 2);

    // Round-robin: all channels held -> 0,1,2,3,0,1 back to back.
    for (int i = 0; i < 6; i++) cycle(1, 8'hF, rnd_data(), 1'b1, 1'b0, 8'h0);
    // Move pointer to 3, then skip/wrap with 4'b0101.
    cycle(1, 8'h4, rnd_data(), 1'b1, 1'b0, 8'h0);
    cycle(1, 8'h5, rnd_data(), 1'b1, 1'b0, 8'h0);
    cycle(1, 8'h5, rnd_data(), 1'b1, 1'b0, 8'h0);
    for (int i = 0; i < 60; i++) begin
      cycle(1, 8'($urandom_range(0, 15)), rnd_data(),
            ($urandom_range(0, 3) != 0), 1'b0, 8'h0);
    end

    // Reset mid-transfer with a word stalled on the output.
    cycle(1, 8'hF, rnd_data(), 1'b0, 1'b0, 8'h0);
    cycle(1, 8'hF, rnd_data(), 1'b0, 1'b0, 8'h0);
    chk("pre_reset_valid", 40'(act_ov[1]), 40'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 40'(act_ov[1]), 40'h0);
    chk("async_rst_out_word",  {24'h0, act_ch[1], act_dt[1]}, 40'h0);
    chk("async_rst_in_ready",  40'(act_ir[1]), 40'h0);
    chk("async_rst_rr_ptr",    40'(act_pt[1]), 40'h0);
    @(negedge clk);
    rst = 1'b0;
    drv_iv[1] = 8'h0;
    drv_ordy[1] = 1'b1;
    model_reset();
    idle(1, 1);

    // Five channels: ch4 alone, then ch0+ch4 -> pointer wraps to ch0.
    cycle(2, 8'h10, rnd_data(), 1'b1, 1'b0, 8'h0);
    cycle(2, 8'h11, rnd_data(), 1'b1, 1'b0, 8'h0);
    for (int i = 0; i < 60; i++) begin
      cycle(2, 8'($urandom_range(0, 31)), rnd_data(),
            ($urandom_range(0, 3) != 0), 1'b0, 8'h0);
    end
    idle(2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
